simplex_register: RTL

//   Serial-to-parallel simplex register. Sits directly upstream of the simplex driver stage.

---
 rtl/simplex_register.sv | 74 +++++++
 1 files changed

// File: rtl/simplex_register.sv
// simplex_register: serial-to-parallel SSR discrete register with timed SSR14H/SSR15H pulses
module simplex_register #(
  parameter int WORD_BITS = 26,
  parameter logic [8:0] SET_ADDR = 9'o041,
  parameter logic [8:0] CLR_ADDR = 9'o042,
  parameter int PULSE_CYCLES = 1024
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       SER_DATA,
  input  logic       SER_SHIFT,
  input  logic       PIO_STROBE,
  input  logic [8:0] PIO_ADDR,
  output logic       SSR1H,
  output logic       SSR2H,
  output logic       SSR3H,
  output logic       SSR4H,
  output logic       SSR5H,
  output logic       SSR6H,
  output logic       SSR7H,
  output logic       SSR8H,
  output logic       SSR14H,
  output logic       SSR15H,
  output logic       BUSY,
  output logic       ERR
);
  localparam int CW = $clog2(WORD_BITS + 2);
  localparam int TW = $clog2(PULSE_CYCLES + 1);
  logic [WORD_BITS-1:0] r_sreg, w_sreg;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [7:0] r_lvl, w_lvl;
  logic [TW-1:0] r_t14, r_t15, w_t14, w_t15;
  logic r_o14, r_o15, r_busy, r_err, w_err, w_set, w_clr, w_load;
  always_comb begin
    w_set = PIO_STROBE && PIO_ADDR == SET_ADDR;
    w_clr = PIO_STROBE && PIO_ADDR == CLR_ADDR;
    w_load = w_set && r_cnt == CW'(WORD_BITS);
    w_sreg = SER_SHIFT ? {r_sreg[WORD_BITS-2:0], SER_DATA} : r_sreg;
    w_cnt = (w_set || w_clr) ? CW'(SER_SHIFT) :
            (SER_SHIFT && r_cnt != CW'(WORD_BITS + 1)) ? r_cnt + CW'(1) : r_cnt;
    w_lvl = w_clr ? '0 : w_load ? r_sreg[WORD_BITS-1 -: 8] : r_lvl;
    w_t14 = w_clr ? '0 : w_load ? (r_sreg[WORD_BITS-9] ? TW'(PULSE_CYCLES) : '0) : r_t14 - TW'(r_t14 != '0);
    w_t15 = w_clr ? '0 : w_load ? (r_sreg[WORD_BITS-10] ? TW'(PULSE_CYCLES) : '0) : r_t15 - TW'(r_t15 != '0);
    w_err = w_clr ? 1'b0 : w_set ? !w_load : r_err;
  end
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      r_sreg <= '0;
      r_cnt <= '0;
      r_lvl <= '0;
      r_t14 <= '0;
      r_t15 <= '0;
      r_o14 <= 1'b0;
      r_o15 <= 1'b0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_sreg <= w_sreg;
      r_cnt <= w_cnt;
      r_lvl <= w_lvl;
      r_t14 <= w_t14;
      r_t15 <= w_t15;
      r_o14 <= w_t14 != '0;
      r_o15 <= w_t15 != '0;
      r_busy <= (w_t14 != '0) || (w_t15 != '0);
      r_err <= w_err;
    end
  end
  assign {SSR1H, SSR2H, SSR3H, SSR4H, SSR5H, SSR6H, SSR7H, SSR8H} = r_lvl;
  assign SSR14H = r_o14;
  assign SSR15H = r_o15;
  assign BUSY = r_busy;
  assign ERR = r_err;
endmodule
